// File: rtl/lcd_msg_pkg.sv
// Shared types and constants for the LCD message arbiter: FSM states,
// source indices and the idle banner text.
package lcd_msg_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      FREE = 2'd2
   } lcd_state_t;

   localparam logic [1:0] SRC_FAULT  = 2'd0;
   localparam logic [1:0] SRC_STATUS = 2'd1;
   localparam logic [1:0] SRC_PROMPT = 2'd2;

   localparam logic [127:0] BANNER_R1 = "COFFEE MACHINE  ";
   localparam logic [127:0] BANNER_R2 = "  READY         ";

endpackage

// File: rtl/lcd_hold_timer.sv
// Minimum-hold counter: clears on a new grant, counts while enabled and
// parks at MIN_HOLD-1 so a long-lived owner never wraps back into its window.
module lcd_hold_timer #(
   parameter int MIN_HOLD = 50000000,
   parameter int HOLD_W   = 26
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam logic [HOLD_W-1:0] LAST = HOLD_W'(MIN_HOLD - 1);

   logic [HOLD_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (en && (count != LAST)) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == LAST);

endmodule

// File: rtl/lcd_msg_arbiter.sv
// Arbitrates the two-row LCD buffer between fault, status and prompt sources
// with a minimum hold time, fault preemption and an idle banner fallback.
module lcd_msg_arbiter
   import lcd_msg_pkg::*;
#(
   parameter int MIN_HOLD = 50000000,
   parameter int HOLD_W   = 26
) (
   input  logic         clk,
   input  logic         RST,
   input  logic [2:0]   req,
   input  logic [127:0] msg0_r1,
   input  logic [127:0] msg0_r2,
   input  logic [127:0] msg1_r1,
   input  logic [127:0] msg1_r2,
   input  logic [127:0] msg2_r1,
   input  logic [127:0] msg2_r2,
   output logic [2:0]   gnt,
   output logic [127:0] row_1,
   output logic [127:0] row_2,
   output logic         msg_chg,
   output logic         busy
);

   lcd_state_t   state, state_n;
   logic [2:0]   gnt_n;
   logic [1:0]   sel;
   logic [127:0] sel_r1, sel_r2, live_r1, live_r2;
   logic [127:0] row_1_n, row_2_n;
   logic         chg_n, hold_clr, expired, live_en;

   function automatic logic [2:0] onehot(input logic [1:0] idx);
      return 3'b001 << idx;
   endfunction

   always_comb begin
      sel = SRC_FAULT;
      if (req[0])      sel = SRC_FAULT;
      else if (req[1]) sel = SRC_STATUS;
      else if (req[2]) sel = SRC_PROMPT;
   end

   always_comb begin
      sel_r1 = msg0_r1;
      sel_r2 = msg0_r2;
      case (sel)
         SRC_STATUS: begin sel_r1 = msg1_r1; sel_r2 = msg1_r2; end
         SRC_PROMPT: begin sel_r1 = msg2_r1; sel_r2 = msg2_r2; end
         default:    begin sel_r1 = msg0_r1; sel_r2 = msg0_r2; end
      endcase
   end

   // Live-update source follows the current owner, not the priority pick.
   always_comb begin
      live_r1 = msg0_r1;
      live_r2 = msg0_r2;
      if (gnt[1]) begin live_r1 = msg1_r1; live_r2 = msg1_r2; end
      if (gnt[2]) begin live_r1 = msg2_r1; live_r2 = msg2_r2; end
   end

   assign live_en = |(gnt & req);

   always_comb begin
      state_n  = state;
      gnt_n    = gnt;
      chg_n    = 1'b0;
      hold_clr = 1'b0;
      row_1_n  = row_1;
      row_2_n  = row_2;
      if (live_en) begin
         row_1_n = live_r1;
         row_2_n = live_r2;
      end
      case (state)
         IDLE: begin
            if (|req) begin
               gnt_n    = onehot(sel);
               row_1_n  = sel_r1;
               row_2_n  = sel_r2;
               hold_clr = 1'b1;
               chg_n    = 1'b1;
               state_n  = SHOW;
            end
         end
         SHOW: begin
            if (req[0] && !gnt[0]) begin
               gnt_n    = onehot(SRC_FAULT);
               row_1_n  = msg0_r1;
               row_2_n  = msg0_r2;
               hold_clr = 1'b1;
               chg_n    = 1'b1;
            end else if (expired) begin
               state_n = FREE;
            end
         end
         FREE: begin
            if (req == 3'b000) begin
               gnt_n   = 3'b000;
               row_1_n = BANNER_R1;
               row_2_n = BANNER_R2;
               chg_n   = 1'b1;
               state_n = IDLE;
            end else if (onehot(sel) != gnt) begin
               gnt_n    = onehot(sel);
               row_1_n  = sel_r1;
               row_2_n  = sel_r2;
               hold_clr = 1'b1;
               chg_n    = 1'b1;
               state_n  = SHOW;
            end
         end
         default: begin
            state_n = IDLE;
            gnt_n   = 3'b000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (RST) begin
         state   <= IDLE;
         gnt     <= 3'b000;
         row_1   <= BANNER_R1;
         row_2   <= BANNER_R2;
         msg_chg <= 1'b0;
      end else begin
         state   <= state_n;
         gnt     <= gnt_n;
         row_1   <= row_1_n;
         row_2   <= row_2_n;
         msg_chg <= chg_n;
      end
   end

   lcd_hold_timer #(
      .MIN_HOLD(MIN_HOLD),
      .HOLD_W  (HOLD_W)
   ) u_hold_timer (
      .clk    (clk),
      .rst    (RST),
      .clr    (hold_clr),
      .en     (state == SHOW),
      .expired(expired)
   );

   assign busy = (state == SHOW);

endmodule
